// File: rtl/sobol_pkg.sv
// Shared definitions for the Sobol sequence generator.
//   DATA_W     : width of samples and direction vectors
//   DIR_ADDR_W : width of the direction-vector table index
//   state_e    : run FSM states
package sobol_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DIR_ADDR_W = 5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/sobol_tz_find.sv
// Combinational trailing-ones counter.
// Returns the number of consecutive 1 bits starting at bit 0 of val_i. This is
// the position of the lowest zero bit, which selects the direction vector in
// Gray-code ordered Sobol generation.
//   val_i : value to scan (InW bits)
//   cnt_o : count of trailing ones (OutW bits)
module sobol_tz_find #(
    parameter int unsigned InW  = 20,
    parameter int unsigned OutW = 5
) (
    input  logic [InW-1:0]  val_i,
    output logic [OutW-1:0] cnt_o
);

    logic stop;

    always_comb begin
        cnt_o = '0;
        stop  = 1'b0;
        for (int unsigned i = 0; i < InW; i++) begin
            if (!stop) begin
                if (val_i[i]) begin
                    cnt_o = cnt_o + 1'b1;
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sobol_seq_gen.sv
// One dimension of a 32-bit Sobol low-discrepancy sequence, Gray-code ordered.
// Each sample is x_n = x_(n-1) ^ v[c], c = trailing ones of (n-1).
// Output is a valid/ready stream; a run of num_samples_i samples is launched by
// start_i and may be cancelled by abort_i. The direction-vector table is
// host-writable whenever no run is active.
//   clk_i          : clock, rising edge
//   rst_ni         : synchronous reset, active low
//   dir_we_i       : direction-vector write strobe
//   dir_addr_i     : direction-vector index
//   dir_data_i     : direction-vector value
//   start_i        : one-cycle start pulse
//   num_samples_i  : samples in this run, sampled on accepted start
//   abort_i        : cancel the current run
//   out_valid_o    : out_data_o holds a valid sample
//   out_ready_i    : downstream accepts the sample
//   out_data_o     : Sobol sample x_n
//   busy_o         : high while a run is active
//   done_o         : one-cycle pulse after the last sample handshake
module sobol_seq_gen
    import sobol_pkg::*;
#(
    parameter int unsigned CNT_W = 20,
    parameter int unsigned DIR_N = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dir_we_i,
    input  logic [DIR_ADDR_W-1:0] dir_addr_i,
    input  logic [DATA_W-1:0]     dir_data_i,
    input  logic                  start_i,
    input  logic [CNT_W-1:0]      num_samples_i,
    input  logic                  abort_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_W-1:0]     out_data_o,
    output logic                  busy_o,
    output logic                  done_o
);

    state_e                  state_q;
    logic [CNT_W-1:0]        idx_q;
    logic [CNT_W-1:0]        num_q;
    logic [DATA_W-1:0]       acc_q;
    logic [DATA_W-1:0]       acc_d;
    logic                    out_valid_q;
    logic [DATA_W-1:0]       out_data_q;
    logic [DATA_W-1:0]       v_q [DIR_N];

    logic [DIR_ADDR_W-1:0]   tz_cnt;
    logic                    advance;
    logic                    last_hs;
    logic                    dir_wr_en;

    sobol_tz_find #(
        .InW  (CNT_W),
        .OutW (DIR_ADDR_W)
    ) u_tz_find (
        .val_i (idx_q),
        .cnt_o (tz_cnt)
    );

    // A new sample may be produced when the output slot is empty or being drained.
    assign advance = (state_q == StRun) && (!out_valid_q || out_ready_i);
    // idx_q counts samples already produced, so the Nth sample is handed off
    // while idx_q == num_q.
    assign last_hs = out_valid_q && out_ready_i && (idx_q == num_q);
    assign acc_d   = acc_q ^ v_q[tz_cnt];

    assign dir_wr_en = dir_we_i && (state_q != StRun) && (32'(dir_addr_i) < DIR_N);

    // Direction-vector table
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DIR_N; i++) begin
                v_q[i] <= '0;
            end
        end else if (dir_wr_en) begin
            v_q[dir_addr_i] <= dir_data_i;
        end
    end

    // Run FSM with accumulator and output register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            num_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        num_q <= num_samples_i;
                        acc_q <= '0;
                        idx_q <= '0;
                        state_q <= (num_samples_i == '0) ? StDone : StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    if (abort_i) begin
                        // Pending sample is dropped and no done pulse follows.
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end else if (last_hs) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StDone;
                    end else if (advance) begin
                        acc_q       <= acc_d;
                        out_data_q  <= acc_d;
                        out_valid_q <= 1'b1;
                        idx_q       <= idx_q + 1'b1;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = (state_q == StRun);
    assign done_o      = (state_q == StDone);

endmodule
